// File: rtl/riscv_pkg.sv
// ---------------------------------------------------------------------------
// riscv_pkg
// Shared definitions for the debug register-dump block.
//   REG_ADDR_W   : width of a register-file address (x0..x31).
//   dump_state_e : states of the reg_dump streaming FSM.
// Optional feature macro: REG_DUMP_CHECKSUM_EN adds the CSUM state, which
// streams a trailing XOR checksum word.
// ---------------------------------------------------------------------------
package riscv_pkg;

    localparam int REG_ADDR_W = 5;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        SEND = 3'd2,
`ifdef REG_DUMP_CHECKSUM_EN
        CSUM = 3'd3,
`endif
        DONE = 3'd4
    } dump_state_e;

endpackage

// File: rtl/reg_dump.sv
// ---------------------------------------------------------------------------
// reg_dump
// Streams the contents of registers x0..x(NUM_REGS-1) out over a
// valid/ready interface. A register-file read port (rs2 in the debug build)
// is driven through rd_addr and its combinational rd_data is captured one
// register per LOAD cycle. The best-case rate is one word per two cycles.
//
// Optional feature macro: REG_DUMP_CHECKSUM_EN
//   When defined, an extra final word holding the XOR of all dumped
//   registers is emitted with out_idx=0 and out_last=1.
//
// Ports
//   clk       in   clock, all state changes on the rising edge
//   rst_n     in   synchronous active-low reset
//   start     in   one-cycle dump request, honoured only when idle
//   rd_addr   out  register-file read address (always the index counter)
//   rd_data   in   read data for rd_addr, same cycle
//   out_valid out  stream word valid
//   out_ready in   consumer ready
//   out_data  out  stream word
//   out_idx   out  register index of out_data (0 for the checksum word)
//   out_last  out  final word of the dump
//   busy      out  dump in progress
//   done      out  one-cycle pulse after the final handshake
// ---------------------------------------------------------------------------
module reg_dump
    import riscv_pkg::*;
#(
    parameter int NUM_REGS = 32,
    parameter int XLEN     = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    output logic [REG_ADDR_W-1:0] rd_addr,
    input  logic [XLEN-1:0]       rd_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [XLEN-1:0]       out_data,
    output logic [REG_ADDR_W-1:0] out_idx,
    output logic                  out_last,
    output logic                  busy,
    output logic                  done
);

    localparam logic [REG_ADDR_W-1:0] LAST_IDX = REG_ADDR_W'(NUM_REGS - 1);

`ifdef REG_DUMP_CHECKSUM_EN
    // The checksum word, not the last register, carries out_last.
    localparam logic LAST_ON_REG = 1'b0;
`else
    localparam logic LAST_ON_REG = 1'b1;
`endif

    dump_state_e           state_q, state_d;
    logic [REG_ADDR_W-1:0] idx_q, idx_d;
    logic                  out_valid_q, out_valid_d;
    logic [XLEN-1:0]       out_data_q, out_data_d;
    logic [REG_ADDR_W-1:0] out_idx_q, out_idx_d;
    logic                  out_last_q, out_last_d;
`ifdef REG_DUMP_CHECKSUM_EN
    logic [XLEN-1:0]       acc_q, acc_d;
`endif

    logic hs;
    assign hs = out_valid_q && out_ready;

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_idx_d   = out_idx_q;
        out_last_d  = out_last_q;
`ifdef REG_DUMP_CHECKSUM_EN
        acc_d       = acc_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    idx_d   = '0;
`ifdef REG_DUMP_CHECKSUM_EN
                    acc_d   = '0;
`endif
                    state_d = LOAD;
                end
            end
            LOAD: begin
                out_data_d  = rd_data;
                out_idx_d   = idx_q;
                out_valid_d = 1'b1;
                out_last_d  = LAST_ON_REG && (idx_q == LAST_IDX);
`ifdef REG_DUMP_CHECKSUM_EN
                acc_d       = acc_q ^ rd_data;
`endif
                state_d     = SEND;
            end
            SEND: begin
                if (hs) begin
                    out_valid_d = 1'b0;
                    out_last_d  = 1'b0;
                    if (idx_q != LAST_IDX) begin
                        idx_d   = idx_q + REG_ADDR_W'(1);
                        state_d = LOAD;
                    end else begin
`ifdef REG_DUMP_CHECKSUM_EN
                        state_d = CSUM;
`else
                        state_d = DONE;
`endif
                    end
                end
            end
`ifdef REG_DUMP_CHECKSUM_EN
            CSUM: begin
                // First cycle presents the checksum; then hold until accepted.
                if (!out_valid_q) begin
                    out_data_d  = acc_q;
                    out_idx_d   = '0;
                    out_last_d  = 1'b1;
                    out_valid_d = 1'b1;
                end else if (out_ready) begin
                    out_valid_d = 1'b0;
                    out_last_d  = 1'b0;
                    state_d     = DONE;
                end
            end
`endif
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_idx_q   <= '0;
            out_last_q  <= 1'b0;
`ifdef REG_DUMP_CHECKSUM_EN
            acc_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_idx_q   <= out_idx_d;
            out_last_q  <= out_last_d;
`ifdef REG_DUMP_CHECKSUM_EN
            acc_q       <= acc_d;
`endif
        end
    end

    assign rd_addr   = idx_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_idx   = out_idx_q;
    assign out_last  = out_last_q;
    assign done      = (state_q == DONE);
`ifdef REG_DUMP_CHECKSUM_EN
    assign busy      = (state_q == LOAD) || (state_q == SEND) || (state_q == CSUM);
`else
    assign busy      = (state_q == LOAD) || (state_q == SEND);
`endif

endmodule
